// File: rtl/noc_route_decoder_sync.sv
// noc_route_decoder_sync: clocked 1-to-2 NoC route decoder with per-port FWFT buffers,
// an in-order select channel and per-port packet counters.
module noc_route_decoder_fifo #(
    parameter int W = 1,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic         full,
    output logic [W-1:0] dout
);
    localparam int AB = $clog2(D);
    localparam int IW = AB > 0 ? AB : 1;
    localparam logic [AB:0] DC = (AB+1)'(D);
    logic [AB:0] wptr, rptr;
    logic [IW-1:0] wi, ri;
    logic [W-1:0] mem [D];
    if (AB == 0) begin : g_one
        assign wi = '0;
        assign ri = '0;
    end else begin : g_idx
        assign wi = wptr[IW-1:0];
        assign ri = rptr[IW-1:0];
    end
    assign valid = wptr != rptr;
    assign full = (wptr - rptr) == DC;
    assign dout = valid ? mem[ri] : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (valid && ready) rptr <= rptr + 1'b1;
        end
    end
    // A push into a full FIFO only happens alongside a pop, so the head slot is free to overwrite.
    always_ff @(posedge clk) begin
        if (push) mem[wi] <= din;
    end
endmodule

module noc_route_decoder_sync #(
    parameter int            AW     = 4,
    parameter int            DW     = 5,
    parameter logic [AW-1:0] ADDR   = 4'b1100,
    parameter logic [AW-1:0] MASK   = 4'b1110,
    parameter bit            LEAF   = 1'b1,
    parameter int            DEPTH  = 2,
    parameter int            SDEPTH = 4,
    localparam int           PW     = AW + DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [PW-1:0] out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [PW-1:0] out1_data,
    output logic          sel_valid,
    input  logic          sel_ready,
    output logic          sel_data,
    output logic [15:0]   pkt_cnt0,
    output logic [15:0]   pkt_cnt1
);
    localparam int L = $countones(MASK);
    localparam int SB = L < AW ? AW - 1 - L : 0;
    if ((!LEAF && MASK == '1) || MASK != ~({AW{1'b1}} >> L)) begin : g_bad_mask
        $error("noc_route_decoder_sync: MASK must be contiguous from the MSB and not all ones in tree mode");
    end
    logic [AW-1:0] addr;
    logic dest, full0, full1, sel_full, acc;
    assign addr = in_data[PW-1 -: AW];
    assign dest = LEAF ? ((addr & MASK) != ADDR) : addr[SB];
    assign in_ready = !reset && !(dest ? full1 : full0) && !sel_full;
    assign acc = in_valid && in_ready;
    noc_route_decoder_fifo #(.W(PW), .D(DEPTH)) u_f0 (
        .clk(clk), .reset(reset), .push(acc && !dest), .din(in_data),
        .ready(out0_ready), .valid(out0_valid), .full(full0), .dout(out0_data)
    );
    noc_route_decoder_fifo #(.W(PW), .D(DEPTH)) u_f1 (
        .clk(clk), .reset(reset), .push(acc && dest), .din(in_data),
        .ready(out1_ready), .valid(out1_valid), .full(full1), .dout(out1_data)
    );
    noc_route_decoder_fifo #(.W(1), .D(SDEPTH)) u_sel (
        .clk(clk), .reset(reset), .push(acc), .din(dest),
        .ready(sel_ready), .valid(sel_valid), .full(sel_full), .dout(sel_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (acc && !dest) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (acc && dest) pkt_cnt1 <= pkt_cnt1 + 16'd1;
        end
    end
endmodule

// File: tb/tb_noc_route_decoder_sync.sv
// tb_noc_route_decoder_sync: directed tests of the route decoder in leaf and tree modes.
module tb_noc_route_decoder_sync;
    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [8:0] in_data = '0, out0_data, out1_data;
    logic out0_valid, out1_valid, sel_valid, sel_data;
    logic o0r = 1'b1, o1r = 1'b1, sr = 1'b1;
    logic [15:0] cnt0, cnt1;
    logic t_valid = 1'b0, t_ready, t_o0v, t_o1v, t_sv, t_sd;
    logic [8:0] t_data = '0, t_o0d, t_o1d;
    logic [15:0] t_c0, t_c1;
    int checks = 0, passes = 0;
    localparam logic [8:0] P1 = 9'b1100_00001, P2 = 9'b1101_10101, P3 = 9'b0011_00000;

    always #5 clk = ~clk;

    noc_route_decoder_sync dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(o0r), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(o1r), .out1_data(out1_data),
        .sel_valid(sel_valid), .sel_ready(sr), .sel_data(sel_data),
        .pkt_cnt0(cnt0), .pkt_cnt1(cnt1)
    );

    noc_route_decoder_sync #(.LEAF(1'b0), .MASK(4'b1000)) dut_t (
        .clk(clk), .reset(reset), .in_valid(t_valid), .in_ready(t_ready), .in_data(t_data),
        .out0_valid(t_o0v), .out0_ready(1'b0), .out0_data(t_o0d),
        .out1_valid(t_o1v), .out1_ready(1'b0), .out1_data(t_o1d),
        .sel_valid(t_sv), .sel_ready(1'b0), .sel_data(t_sd),
        .pkt_cnt0(t_c0), .pkt_cnt1(t_c1)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data = P1;
        cyc();
        cyc();
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else passes++;
        checks++; if (out0_valid !== 1'b0) $display("FAIL rst_out0_valid got %b exp 0", out0_valid); else passes++;
        checks++; if (out1_valid !== 1'b0) $display("FAIL rst_out1_valid got %b exp 0", out1_valid); else passes++;
        checks++; if (sel_valid !== 1'b0) $display("FAIL rst_sel_valid got %b exp 0", sel_valid); else passes++;
        checks++; if (out0_data !== 9'd0) $display("FAIL rst_out0_data got %h exp 0", out0_data); else passes++;
        checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) $display("FAIL rst_cnt got %h/%h exp 0/0", cnt0, cnt1); else passes++;
        reset = 1'b0;
        in_valid = 1'b0;
        cyc();
        checks++; if (out0_valid !== 1'b0) $display("FAIL rst_drop got %b exp 0", out0_valid); else passes++;
    endtask

    task automatic test_leaf();
        o0r = 1'b0; o1r = 1'b0; sr = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_data = P1;
        cyc();
        checks++; if (out0_valid !== 1'b1 || out0_data !== P1) $display("FAIL leaf_p1 got %b/%h exp 1/%h", out0_valid, out0_data, P1); else passes++;
        checks++; if (sel_valid !== 1'b1 || sel_data !== 1'b0) $display("FAIL leaf_sel1 got %b/%b exp 1/0", sel_valid, sel_data); else passes++;
        in_data = P2;
        cyc();
        checks++; if (out0_data !== P1) $display("FAIL leaf_hold got %h exp %h", out0_data, P1); else passes++;
        in_data = P3;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL leaf_ready_p3 got %b exp 1", in_ready); else passes++;
        cyc();
        in_valid = 1'b0;
        checks++; if (out1_valid !== 1'b1 || out1_data !== P3) $display("FAIL leaf_p3 got %b/%h exp 1/%h", out1_valid, out1_data, P3); else passes++;
        checks++; if (cnt0 !== 16'd2 || cnt1 !== 16'd1) $display("FAIL leaf_cnt got %0d/%0d exp 2/1", cnt0, cnt1); else passes++;
        o0r = 1'b1; o1r = 1'b1; sr = 1'b1;
        cyc();
        checks++; if (out0_data !== P2) $display("FAIL leaf_p2 got %h exp %h", out0_data, P2); else passes++;
        checks++; if (out1_valid !== 1'b0) $display("FAIL leaf_o1_empty got %b exp 0", out1_valid); else passes++;
        checks++; if (sel_data !== 1'b0) $display("FAIL leaf_sel2 got %b exp 0", sel_data); else passes++;
        cyc();
        checks++; if (out0_valid !== 1'b0) $display("FAIL leaf_o0_empty got %b exp 0", out0_valid); else passes++;
        checks++; if (sel_valid !== 1'b1 || sel_data !== 1'b1) $display("FAIL leaf_sel3 got %b/%b exp 1/1", sel_valid, sel_data); else passes++;
        cyc();
        checks++; if (sel_valid !== 1'b0) $display("FAIL leaf_sel_empty got %b exp 0", sel_valid); else passes++;
    endtask

    task automatic test_tree();
        t_valid = 1'b1;
        t_data = 9'b1011_00000;
        cyc();
        t_data = 9'b0100_00000;
        checks++; if (t_o0v !== 1'b1 || t_o0d !== 9'b1011_00000) $display("FAIL tree_p0 got %b/%h exp 1/%h", t_o0v, t_o0d, 9'b1011_00000); else passes++;
        checks++; if (t_sv !== 1'b1 || t_sd !== 1'b0) $display("FAIL tree_sel got %b/%b exp 1/0", t_sv, t_sd); else passes++;
        cyc();
        t_valid = 1'b0;
        checks++; if (t_o1v !== 1'b1 || t_o1d !== 9'b0100_00000) $display("FAIL tree_p1 got %b/%h exp 1/%h", t_o1v, t_o1d, 9'b0100_00000); else passes++;
        checks++; if (t_c0 !== 16'd1 || t_c1 !== 16'd1) $display("FAIL tree_cnt got %0d/%0d exp 1/1", t_c0, t_c1); else passes++;
    endtask

    task automatic test_port_stall();
        o0r = 1'b1; o1r = 1'b0; sr = 1'b1;
        do_reset();
        in_valid = 1'b1;
        in_data = 9'b0011_00001;
        cyc();
        in_data = 9'b0011_00010;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL stall_ready2 got %b exp 1", in_ready); else passes++;
        cyc();
        in_data = 9'b0011_00011;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready3 got %b exp 0", in_ready); else passes++;
        cyc();
        checks++; if (out1_data !== 9'b0011_00001 || cnt1 !== 16'd2) $display("FAIL stall_hold got %h/%0d exp %h/2", out1_data, cnt1, 9'b0011_00001); else passes++;
        in_data = 9'b1100_00111;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL stall_p0_ready got %b exp 1", in_ready); else passes++;
        cyc();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 9'b1100_00111 || cnt0 !== 16'd1) $display("FAIL stall_p0 got %b/%h/%0d exp 1/%h/1", out0_valid, out0_data, cnt0, 9'b1100_00111); else passes++;
        in_data = 9'b0011_00011;
        o1r = 1'b1;
        cyc();
        #1;
        checks++; if (in_ready !== 1'b1 || out1_data !== 9'b0011_00010) $display("FAIL stall_release got %b/%h exp 1/%h", in_ready, out1_data, 9'b0011_00010); else passes++;
        cyc();
        in_valid = 1'b0;
        checks++; if (out1_data !== 9'b0011_00011 || cnt1 !== 16'd3) $display("FAIL stall_p3 got %h/%0d exp %h/3", out1_data, cnt1, 9'b0011_00011); else passes++;
    endtask

    task automatic test_sel_full();
        logic [8:0] s [6];
        int idx = 0;
        s[0] = 9'b1100_00001; s[1] = 9'b0011_00010; s[2] = 9'b1100_00011;
        s[3] = 9'b0011_00100; s[4] = 9'b0011_00101; s[5] = 9'b1100_00110;
        o0r = 1'b1; o1r = 1'b1; sr = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = s[idx];
            #1;
            if (in_ready) idx++;
            cyc();
        end
        in_valid = 1'b0;
        in_data = s[idx];
        #1;
        checks++; if (idx !== 4) $display("FAIL sel_accepted got %0d exp 4", idx); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL sel_full_ready got %b exp 0", in_ready); else passes++;
        checks++; if (cnt0 !== 16'd2 || cnt1 !== 16'd2) $display("FAIL sel_cnt got %0d/%0d exp 2/2", cnt0, cnt1); else passes++;
        checks++; if (sel_data !== 1'b0) $display("FAIL sel_tok0 got %b exp 0", sel_data); else passes++;
        sr = 1'b1;
        cyc();
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL sel_room_ready got %b exp 1", in_ready); else passes++;
        checks++; if (sel_data !== 1'b1) $display("FAIL sel_tok1 got %b exp 1", sel_data); else passes++;
        cyc();
        checks++; if (sel_data !== 1'b0) $display("FAIL sel_tok2 got %b exp 0", sel_data); else passes++;
        cyc();
        checks++; if (sel_data !== 1'b1) $display("FAIL sel_tok3 got %b exp 1", sel_data); else passes++;
        cyc();
        checks++; if (sel_valid !== 1'b0) $display("FAIL sel_drained got %b exp 0", sel_valid); else passes++;
    endtask

    task automatic test_back_to_back();
        int wr = 0, rd = 0;
        o0r = 1'b0; o1r = 1'b1; sr = 1'b1;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = {4'b1100, 5'(wr)};
            wr++;
            cyc();
        end
        in_data = {4'b1100, 5'(wr)};
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready got %b exp 0", in_ready); else passes++;
        o0r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (out0_valid !== 1'b1 || out0_data !== {4'b1100, 5'(rd)}) $display("FAIL b2b_data got %b/%h exp 1/%h", out0_valid, out0_data, {4'b1100, 5'(rd)}); else passes++;
            rd++;
            in_data = {4'b1100, 5'(wr)};
            #1;
            if (in_ready) wr++;
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out0_valid) begin
                checks++; if (out0_data !== {4'b1100, 5'(rd)}) $display("FAIL b2b_drain got %h exp %h", out0_data, {4'b1100, 5'(rd)}); else passes++;
                rd++;
            end
            cyc();
        end
        checks++; if (wr !== 21) $display("FAIL b2b_pushed got %0d exp 21", wr); else passes++;
        checks++; if (rd !== 21 || out0_valid !== 1'b0) $display("FAIL b2b_popped got %0d/%b exp 21/0", rd, out0_valid); else passes++;
    endtask

    task automatic test_mid_reset();
        o0r = 1'b0; o1r = 1'b0; sr = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_data = P1;
        cyc();
        in_data = P3;
        cyc();
        checks++; if ({out0_valid, out1_valid, sel_valid} !== 3'b111) $display("FAIL mid_filled got %b exp 111", {out0_valid, out1_valid, sel_valid}); else passes++;
        reset = 1'b1;
        in_data = P2;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL mid_ready got %b exp 0", in_ready); else passes++;
        cyc();
        checks++; if ({out0_valid, out1_valid, sel_valid} !== 3'b000) $display("FAIL mid_valids got %b exp 000", {out0_valid, out1_valid, sel_valid}); else passes++;
        checks++; if (out0_data !== 9'd0 || out1_data !== 9'd0) $display("FAIL mid_data got %h/%h exp 0/0", out0_data, out1_data); else passes++;
        checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) $display("FAIL mid_cnt got %0d/%0d exp 0/0", cnt0, cnt1); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out0_valid !== 1'b0) $display("FAIL mid_after got %b/%b exp 1/0", in_ready, out0_valid); else passes++;
        cyc();
        in_valid = 1'b0;
        checks++; if (out0_valid !== 1'b1 || out0_data !== P2 || cnt0 !== 16'd1) $display("FAIL mid_latency got %b/%h/%0d exp 1/%h/1", out0_valid, out0_data, cnt0, P2); else passes++;
    endtask

    initial begin
        test_reset();
        test_leaf();
        test_tree();
        test_port_stall();
        test_sel_full();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end
endmodule
